udp_key_lookup: RTL and testbench
=================================

// Module: udp_key_lookup
// PURPOSE
// - Upstream stage of the host ACK path. Holds a small table of registered 64-bit UDP keys.
// - For each lookup request, emits {key, hit/miss result} on the key/result stream that the
//   ACK builder consumes.
// - The table is maintained through a separate insert/delete command stream.
// - Each operation is a sequential scan of one entry per cycle, controlled by an IDLE/SCAN/RESP FSM.
// PARAMETERS
// - KEY_W  64  key width in bits; must equal the downstream key width.
// - DEPTH  16  number of table entries (>=2). IDX_W = $clog2(DEPTH) is a derived localparam.
// PORTS
// - clk                     in   1          single clock; all logic is posedge clk.
// - rst                     in   1          asynchronous, active-high reset.
// - s_axis_key_req_valid    in   1          lookup request valid.
// - s_axis_key_req_ready    out  1          lookup request ready.
// - s_axis_key_req          in   KEY_W      key to look up.
// - s_axis_tbl_valid        in   1          table command valid.
// - s_axis_tbl_ready        out  1          table command ready.
// - s_axis_tbl_key          in   KEY_W      key to insert or delete.
// - s_axis_tbl_op           in   1          1 = insert, 0 = delete.
// - m_axis_key_udp_valid    out  1          result valid.
// - m_axis_key_udp_ready    in   1          result ready, from the ACK builder.
// - m_axis_key_udp          out  KEY_W      looked-up key, echoed.
// - m_axis_key_udp_result   out  1          1 = key present in table (hit).
// - tbl_count               out  IDX_W+1    number of valid entries.
// - tbl_full                out  1          tbl_count == DEPTH.
// - ins_drop                out  1          one-cycle pulse: insert of a new key dropped because table full.
// BEHAVIOUR
// Reset (async assert, sync release):
// - Table is entry valid[DEPTH] + key[DEPTH]. Reset clears all valid bits; key storage is not reset.
// - Reset values: FSM = IDLE; tbl_count = 0; tbl_full = 0; ins_drop = 0; m_axis_key_udp_valid = 0;
//   m_axis_key_udp = 0; m_axis_key_udp_result = 0.
// - Reset mid-scan or mid-RESP aborts the operation. No response is produced afterwards.
// Input ready (combinational from state only):
// - s_axis_tbl_ready = (state == IDLE).
// - s_axis_key_req_ready = (state == IDLE) && !s_axis_tbl_valid. Table commands have priority when
//   both inputs are valid; the lookup waits.
// - Both ready signals are low in SCAN and RESP. At most one operation is in flight.
// Accept (IDLE, handshake at cycle T):
// - Latch key, op type (LOOKUP / INSERT / DELETE), idx = 0. Clear the hit and free-slot-found flags.
//   Go to SCAN.
// SCAN (entry idx compared at cycle T+1+idx):
// - match = valid[idx] && key[idx] == latched key.
// - LOOKUP: on match, go to RESP with result = 1. If idx == DEPTH-1 and no match, go to RESP with
//   result = 0.
// - DELETE: on match, clear valid[idx], decrement tbl_count, go to IDLE. No match at the last entry:
//   go to IDLE with no change.
// - INSERT: record the lowest idx with !valid[idx] as the free slot. On match (duplicate), go to IDLE
//   with no change. At the last entry with no match: if a free slot exists, write key and set valid
//   at that slot, increment tbl_count; otherwise pulse ins_drop. Then go to IDLE.
// - Duplicate entries never exist; table invariant: all valid keys are distinct.
// RESP:
// - m_axis_key_udp_valid = 1; m_axis_key_udp and m_axis_key_udp_result are registered and stable
//   until the handshake.
// - On valid && ready: deassert valid the same edge, go to IDLE. The next accept is possible on the
//   following cycle.
// - Backpressure may last indefinitely; no input is accepted meanwhile.
// Latency:
// - LOOKUP hit at idx i: result valid at T+2+i.
// - LOOKUP miss: result valid at T+1+DEPTH.
// - DELETE/INSERT: back in IDLE at T+2+(idx of match) or T+1+DEPTH.
// Widths and flags:
// - tbl_count never wraps; it is bounded to 0..DEPTH by construction.
// - tbl_full is a registered compare, updated on the same edge as tbl_count.
// TESTING
// - Reset, then lookup key 64'h1234 -> miss response {64'h1234, 0} at T+1+16 = T+17;
//   tbl_count = 0 throughout.
// - Insert 64'hA, insert 64'hB, lookup 64'hB -> hit at idx 1, response {64'hB, 1} at T+3;
//   tbl_count = 2.
// - Insert 16 distinct keys -> tbl_full = 1. Insert a 17th new key -> ins_drop pulses once,
//   tbl_count stays 16. Re-insert an existing key -> no ins_drop, no change.
// - Delete 64'hA, lookup 64'hA -> miss. Insert 64'hC -> lands in freed slot 0;
//   lookup 64'hC -> hit at T+2.
// - Tbl command and lookup valid on the same cycle -> tbl command accepted first;
//   lookup accepted only after IDLE is reached again.
// - Hold m_axis_key_udp_ready = 0 for 20 cycles in RESP -> valid, key and result stay stable, both
//   input readys stay 0.
// - Assert rst mid-SCAN -> valid bits clear, no response emitted, tbl_count = 0.

Source files
------------

// File: rtl/udp_key_lookup.sv
// Small key table: answers lookups with {key, hit} and takes insert/delete commands.
// Each operation scans one entry per cycle; only one operation is in flight at a time.
`timescale 1ns/1ps
module udp_key_lookup #(
  parameter int KEY_W = 64,
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_axis_key_req_valid,
  output logic               s_axis_key_req_ready,
  input  logic [KEY_W-1:0]   s_axis_key_req,
  input  logic               s_axis_tbl_valid,
  output logic               s_axis_tbl_ready,
  input  logic [KEY_W-1:0]   s_axis_tbl_key,
  input  logic               s_axis_tbl_op,
  output logic               m_axis_key_udp_valid,
  input  logic               m_axis_key_udp_ready,
  output logic [KEY_W-1:0]   m_axis_key_udp,
  output logic               m_axis_key_udp_result,
  output logic [$clog2(DEPTH):0] tbl_count,
  output logic               tbl_full,
  output logic               ins_drop
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  typedef enum logic [1:0] {OP_LOOKUP, OP_INSERT, OP_DELETE} op_t;

  state_t state, state_nxt;
  op_t op;
  logic [KEY_W-1:0] lat_key;
  logic [IDX_W-1:0] idx;
  logic free_found;
  logic [IDX_W-1:0] free_idx;
  logic [DEPTH-1:0] valid;
  logic [KEY_W-1:0] keys [DEPTH];
  logic [IDX_W:0] count, count_nxt;

  logic tbl_acc, req_acc, last, match;
  logic slot_avail;
  logic [IDX_W-1:0] ins_slot;
  logic do_write, do_clear, do_drop, resp_load, resp_res;

  assign s_axis_tbl_ready     = (state == IDLE);
  assign s_axis_key_req_ready = (state == IDLE) && !s_axis_tbl_valid;
  assign tbl_acc = s_axis_tbl_valid && s_axis_tbl_ready;
  assign req_acc = s_axis_key_req_valid && s_axis_key_req_ready;

  assign last  = (idx == IDX_W'(DEPTH - 1));
  assign match = valid[idx] && (keys[idx] == lat_key);
  // The entry under the cursor still counts as a free slot on the final cycle.
  assign slot_avail = free_found || !valid[idx];
  assign ins_slot   = free_found ? free_idx : idx;

  assign m_axis_key_udp_valid = (state == RESP);
  assign tbl_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    do_clear  = 1'b0;
    do_drop   = 1'b0;
    resp_load = 1'b0;
    resp_res  = 1'b0;
    case (state)
      IDLE: begin
        if (tbl_acc || req_acc) state_nxt = SCAN;
      end
      SCAN: begin
        case (op)
          OP_LOOKUP: begin
            if (match || last) begin
              state_nxt = RESP;
              resp_load = 1'b1;
              resp_res  = match;
            end
          end
          OP_DELETE: begin
            if (match) begin
              do_clear  = 1'b1;
              state_nxt = IDLE;
            end else if (last) begin
              state_nxt = IDLE;
            end
          end
          OP_INSERT: begin
            if (match) begin
              state_nxt = IDLE;
            end else if (last) begin
              if (slot_avail) do_write = 1'b1;
              else            do_drop  = 1'b1;
              state_nxt = IDLE;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
      RESP: begin
        if (m_axis_key_udp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (do_write)      count_nxt = count + (IDX_W+1)'(1);
    else if (do_clear) count_nxt = count - (IDX_W+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op         <= OP_LOOKUP;
      lat_key    <= '0;
      idx        <= '0;
      free_found <= 1'b0;
      free_idx   <= '0;
    end else if (state == IDLE && (tbl_acc || req_acc)) begin
      lat_key    <= tbl_acc ? s_axis_tbl_key : s_axis_key_req;
      op         <= !tbl_acc ? OP_LOOKUP : (s_axis_tbl_op ? OP_INSERT : OP_DELETE);
      idx        <= '0;
      free_found <= 1'b0;
      free_idx   <= '0;
    end else if (state == SCAN) begin
      idx <= idx + IDX_W'(1);
      if (!free_found && !valid[idx]) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (do_clear) valid[idx]      <= 1'b0;
      if (do_write) valid[ins_slot] <= 1'b1;
    end
  end

  // Key storage carries no reset; an entry is only meaningful while its valid bit is set.
  always_ff @(posedge clk) begin
    if (do_write) keys[ins_slot] <= lat_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      tbl_full <= 1'b0;
      ins_drop <= 1'b0;
    end else begin
      count    <= count_nxt;
      tbl_full <= (count_nxt == (IDX_W+1)'(DEPTH));
      ins_drop <= do_drop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_key_udp        <= '0;
      m_axis_key_udp_result <= 1'b0;
    end else if (resp_load) begin
      m_axis_key_udp        <= lat_key;
      m_axis_key_udp_result <= resp_res;
    end
  end
endmodule

// File: tb/tb_udp_key_lookup.sv
// Bench for udp_key_lookup: directed scenarios plus random traffic against a slot-array model.
`timescale 1ns/1ps
module tb_udp_key_lookup;
  localparam int KEY_W = 64;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_axis_key_req_valid = 1'b0;
  logic s_axis_key_req_ready;
  logic [KEY_W-1:0] s_axis_key_req = '0;
  logic s_axis_tbl_valid = 1'b0;
  logic s_axis_tbl_ready;
  logic [KEY_W-1:0] s_axis_tbl_key = '0;
  logic s_axis_tbl_op = 1'b0;
  logic m_axis_key_udp_valid;
  logic m_axis_key_udp_ready = 1'b0;
  logic [KEY_W-1:0] m_axis_key_udp;
  logic m_axis_key_udp_result;
  logic [4:0] tbl_count;
  logic tbl_full;
  logic ins_drop;

  udp_key_lookup #(.KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_key_req_valid(s_axis_key_req_valid), .s_axis_key_req_ready(s_axis_key_req_ready),
    .s_axis_key_req(s_axis_key_req),
    .s_axis_tbl_valid(s_axis_tbl_valid), .s_axis_tbl_ready(s_axis_tbl_ready),
    .s_axis_tbl_key(s_axis_tbl_key), .s_axis_tbl_op(s_axis_tbl_op),
    .m_axis_key_udp_valid(m_axis_key_udp_valid), .m_axis_key_udp_ready(m_axis_key_udp_ready),
    .m_axis_key_udp(m_axis_key_udp), .m_axis_key_udp_result(m_axis_key_udp_result),
    .tbl_count(tbl_count), .tbl_full(tbl_full), .ins_drop(ins_drop)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int drop_cnt = 0;

  // Model: slot array; slot choice only matters for scan latency.
  bit mdl_v [DEPTH];
  logic [KEY_W-1:0] mdl_k [DEPTH];
  bit exp_idle = 1'b1;
  bit exp_vld = 1'b0;
  bit exp_res = 1'b0;
  bit exp_drop = 1'b0;
  logic [KEY_W-1:0] exp_key = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int mdl_count();
    int c = 0;
    for (int j = 0; j < DEPTH; j++) c += int'(mdl_v[j]);
    return c;
  endfunction

  task automatic find(input logic [KEY_W-1:0] k, output int i, output bit hit);
    hit = 1'b0;
    i = DEPTH - 1;
    for (int j = DEPTH - 1; j >= 0; j--)
      if (mdl_v[j] && mdl_k[j] == k) begin hit = 1'b1; i = j; end
  endtask

  task automatic mdl_reset();
    for (int j = 0; j < DEPTH; j++) mdl_v[j] = 1'b0;
  endtask

  always @(negedge clk) begin
    chk("tbl_ready", s_axis_tbl_ready, exp_idle);
    chk("req_ready", s_axis_key_req_ready, exp_idle && !s_axis_tbl_valid);
    chk("m_valid", m_axis_key_udp_valid, exp_vld);
    if (exp_vld) begin
      chk("m_key", m_axis_key_udp, exp_key);
      chk("m_result", m_axis_key_udp_result, exp_res);
    end
    chk("tbl_count", tbl_count, mdl_count());
    chk("tbl_full", tbl_full, mdl_count() == DEPTH);
    chk("ins_drop", ins_drop, exp_drop);
    if (ins_drop === 1'b1) drop_cnt++;
  end

  // The drop pulse lasts exactly one cycle.
  always begin
    @(posedge clk);
    if (exp_drop) begin #1; exp_drop = 1'b0; end
  end

  task automatic run_tbl(input bit ins, input logic [KEY_W-1:0] k);
    int i, d, fs;
    bit hit, ok;
    find(k, i, hit);
    d = hit ? i + 1 : DEPTH;
    s_axis_tbl_key = k;
    s_axis_tbl_op = ins;
    s_axis_tbl_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = s_axis_tbl_ready; end
    if (!ok) begin
      chk("tbl_handshake_timeout", 0, 1);
      s_axis_tbl_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axis_tbl_valid = 1'b0;
    exp_idle = 1'b0;
    repeat (d) @(posedge clk);
    #1;
    if (ins && !hit) begin
      fs = -1;
      for (int j = DEPTH - 1; j >= 0; j--) if (!mdl_v[j]) fs = j;
      if (fs >= 0) begin mdl_v[fs] = 1'b1; mdl_k[fs] = k; end
      else exp_drop = 1'b1;
    end else if (!ins && hit) begin
      mdl_v[i] = 1'b0;
    end
    exp_idle = 1'b1;
  endtask

  task automatic run_lookup(input logic [KEY_W-1:0] k, input int hold, output int lat);
    int i, d;
    bit hit, ok;
    find(k, i, hit);
    d = hit ? i + 1 : DEPTH;
    lat = d + 1;
    s_axis_key_req = k;
    s_axis_key_req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = s_axis_key_req_ready; end
    if (!ok) begin
      chk("req_handshake_timeout", 0, 1);
      s_axis_key_req_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk); #1;
    s_axis_key_req_valid = 1'b0;
    exp_idle = 1'b0;
    repeat (d) @(posedge clk);
    #1;
    exp_vld = 1'b1;
    exp_key = k;
    exp_res = hit;
    repeat (hold) @(posedge clk);
    #1;
    m_axis_key_udp_ready = 1'b1;
    @(posedge clk); #1;
    m_axis_key_udp_ready = 1'b0;
    exp_vld = 1'b0;
    exp_idle = 1'b1;
  endtask

  initial begin
    int lat, r;
    bit ok;
    logic [KEY_W-1:0] k;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_lookup(64'h1234, 0, lat);
    chk("miss_latency", lat, 17);
    chk("count_after_miss", tbl_count, 0);

    run_tbl(1'b1, 64'hA);
    run_tbl(1'b1, 64'hB);
    run_lookup(64'hB, 0, lat);
    chk("hit_idx1_latency", lat, 3);
    chk("count_two", tbl_count, 2);

    for (int j = 0; j < 14; j++) run_tbl(1'b1, 64'(100 + j));
    chk("full_after_16", tbl_full, 1);
    chk("no_drop_yet", drop_cnt, 0);
    run_tbl(1'b1, 64'd200);
    @(posedge clk); @(posedge clk); #1;
    chk("drop_once", drop_cnt, 1);
    chk("count_stays_16", tbl_count, 16);
    run_tbl(1'b1, 64'hB);
    @(posedge clk); @(posedge clk); #1;
    chk("dup_no_drop", drop_cnt, 1);
    chk("dup_count_16", tbl_count, 16);

    run_tbl(1'b0, 64'hA);
    run_lookup(64'hA, 0, lat);
    chk("deleted_miss_latency", lat, 17);
    run_tbl(1'b1, 64'hC);
    run_lookup(64'hC, 0, lat);
    chk("freed_slot0_latency", lat, 2);

    // Both inputs valid together: the table command wins.
    s_axis_key_req = 64'hC;
    s_axis_key_req_valid = 1'b1;
    run_tbl(1'b0, 64'hC);
    run_lookup(64'hC, 0, lat);
    chk("after_delete_latency", lat, 17);

    run_lookup(64'hB, 20, lat);
    chk("held_hit_latency", lat, 3);

    for (int n = 0; n < 220; n++) begin
      k = 64'h500 + 64'($urandom_range(0, 23));
      r = $urandom_range(0, 99);
      if (r < 35) run_tbl(1'b1, k);
      else if (r < 55) run_tbl(1'b0, k);
      else if (r < 85) run_lookup(k, $urandom_range(0, 3), lat);
      else begin
        s_axis_key_req = k;
        s_axis_key_req_valid = 1'b1;
        run_tbl(r[0], 64'h500 + 64'($urandom_range(0, 23)));
        run_lookup(k, $urandom_range(0, 2), lat);
      end
    end

    // Reset in the middle of a scan aborts it with no response.
    if (mdl_count() == 0) run_tbl(1'b1, 64'h777);
    s_axis_key_req = 64'hDEAD;
    s_axis_key_req_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = s_axis_key_req_ready; end
    if (!ok) chk("rst_req_timeout", 0, 1);
    @(posedge clk); #1;
    s_axis_key_req_valid = 1'b0;
    exp_idle = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    mdl_reset();
    exp_idle = 1'b1;
    exp_vld = 1'b0;
    exp_drop = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("count_after_rst", tbl_count, 0);
    chk("full_after_rst", tbl_full, 0);
    run_lookup(64'hB, 0, lat);
    chk("lookup_after_rst_latency", lat, 17);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
